pfd_loop_ctrl: RTL

Consumer end of the PFD interface. It takes the asynchronous flagu/flagd pulses from pfd_model and measures each pulse width in system-clock cycles. The measured up/down difference drives a digital PI loop filter that produces a saturated DCO control code, plus lock detection. It sits between pfd_model and the DCO/feedback divider, closing the loop that generates fb.

---
 rtl/pfd_loop_pkg.sv | 36 +++
 rtl/pfd_sync2.sv | 31 +++
 rtl/pfd_loop_ctrl.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/pfd_loop_pkg.sv
// Shared definitions for the PFD loop controller: state encoding, default
// widths/gains/lock constants and a saturating-add helper.
package pfd_loop_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MEAS   = 2'd1,
    ST_CALC   = 2'd2,
    ST_UPDATE = 2'd3
  } state_e;

  localparam int DEF_CODE_W    = 8;
  localparam int DEF_CNT_W     = 6;
  localparam int DEF_KP_SHIFT  = 1;
  localparam int DEF_KI_SHIFT  = 3;
  localparam int DEF_CODE_INIT = 128;
  localparam int DEF_LOCK_TOL  = 1;
  localparam int DEF_LOCK_CNT  = 16;

  // Signed add clamped to [lo, hi]; operands are small enough not to wrap 32 bits.
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input logic signed [31:0] lo,
                                                 input logic signed [31:0] hi);
    logic signed [31:0] s;
    s = a + b;
    if (s > hi) begin
      return hi;
    end else if (s < lo) begin
      return lo;
    end else begin
      return s;
    end
  endfunction

endpackage

// File: rtl/pfd_sync2.sv
// Two-flop synchronizer bringing an asynchronous PFD flag into the clk domain.
module pfd_sync2 (
  input  logic clk,
  input  logic RESET,
  input  logic d,
  output logic q
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;

  // Next values of the synchronizer chain
  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  // Synchronizer flops, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!RESET) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/pfd_loop_ctrl.sv
// PFD consumer: measures up/down pulse widths, runs a saturating PI filter to
// produce the DCO control code, and tracks loop lock.
module pfd_loop_ctrl
  import pfd_loop_pkg::*;
#(
  parameter int CODE_W    = DEF_CODE_W,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int KP_SHIFT  = DEF_KP_SHIFT,
  parameter int KI_SHIFT  = DEF_KI_SHIFT,
  parameter int CODE_INIT = DEF_CODE_INIT,
  parameter int LOCK_TOL  = DEF_LOCK_TOL,
  parameter int LOCK_CNT  = DEF_LOCK_CNT
) (
  input  logic                     clk,
  input  logic                     RESET,
  input  logic                     flagu,
  input  logic                     flagd,
  output logic [CODE_W-1:0]        ctrl_code,
  output logic signed [CNT_W:0]    err,
  output logic                     err_valid,
  output logic                     locked,
  output logic                     up_sat,
  output logic                     dn_sat,
  output logic                     ovr
);

  localparam int INT_W = CODE_W + KI_SHIFT + 1;
  localparam int LCW   = $clog2(LOCK_CNT + 1);

  localparam logic signed [31:0] CNT_MAX_S   = 32'(2**CNT_W - 1);
  localparam logic signed [31:0] INT_MAX_S   = 32'(2**(CODE_W + KI_SHIFT) - 1);
  localparam logic signed [31:0] INT_MIN_S   = -INT_MAX_S;
  localparam logic signed [31:0] CODE_MAX_S  = 32'(2**CODE_W - 1);
  localparam logic signed [31:0] CODE_INIT_S = 32'(CODE_INIT);
  localparam logic signed [CNT_W:0] TOL_S    = (CNT_W+1)'(LOCK_TOL);
  localparam logic [LCW-1:0]     LOCK_CNT_L  = LCW'(LOCK_CNT);

  logic fu_s, fd_s;

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         up_cnt_q, up_cnt_d, dn_cnt_q, dn_cnt_d;
  logic signed [CNT_W:0]    err_q, err_d;
  logic signed [INT_W-1:0]  integ_q, integ_d;
  logic [CODE_W-1:0]        ctrl_code_q, ctrl_code_d;
  logic [LCW-1:0]           lock_cnt_q, lock_cnt_d;
  logic                     err_valid_q, err_valid_d;
  logic                     locked_q, locked_d;
  logic                     up_sat_q, up_sat_d, dn_sat_q, dn_sat_d;
  logic                     ovr_q, ovr_d;

  logic signed [31:0]       up_inc_w, dn_inc_w, err_w, integ_w, sum_w;

  pfd_sync2 u_sync_up (.clk(clk), .RESET(RESET), .d(flagu), .q(fu_s));
  pfd_sync2 u_sync_dn (.clk(clk), .RESET(RESET), .d(flagd), .q(fd_s));

  // Next-state, measurement and PI filter datapath
  always_comb begin
    state_d     = state_q;
    up_cnt_d    = up_cnt_q;
    dn_cnt_d    = dn_cnt_q;
    err_d       = err_q;
    integ_d     = integ_q;
    ctrl_code_d = ctrl_code_q;
    lock_cnt_d  = lock_cnt_q;
    locked_d    = locked_q;
    up_sat_d    = up_sat_q;
    dn_sat_d    = dn_sat_q;
    ovr_d       = ovr_q;
    err_valid_d = 1'b0;

    up_inc_w = sat_add(32'(up_cnt_q), 32'(fu_s), 32'sd0, CNT_MAX_S);
    dn_inc_w = sat_add(32'(dn_cnt_q), 32'(fd_s), 32'sd0, CNT_MAX_S);
    err_w    = 32'(err_q);
    integ_w  = sat_add(32'(integ_q), err_w, INT_MIN_S, INT_MAX_S);
    sum_w    = CODE_INIT_S + (err_w >>> KP_SHIFT) + (integ_w >>> KI_SHIFT);

    case (state_q)
      ST_IDLE: begin
        if (fu_s || fd_s) begin
          state_d  = ST_MEAS;
          up_cnt_d = CNT_W'(fu_s);
          dn_cnt_d = CNT_W'(fd_s);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MEAS: begin
        if (!fu_s && !fd_s) begin
          err_d       = $signed({1'b0, up_cnt_q}) - $signed({1'b0, dn_cnt_q});
          err_valid_d = 1'b1;
          state_d     = ST_CALC;
        end else begin
          up_cnt_d = up_inc_w[CNT_W-1:0];
          dn_cnt_d = dn_inc_w[CNT_W-1:0];
        end
      end
      ST_CALC: begin
        integ_d = integ_w[INT_W-1:0];
        if (sum_w > CODE_MAX_S) begin
          ctrl_code_d = CODE_MAX_S[CODE_W-1:0];
          up_sat_d    = 1'b1;
          dn_sat_d    = 1'b0;
        end else if (sum_w < 32'sd0) begin
          ctrl_code_d = '0;
          up_sat_d    = 1'b0;
          dn_sat_d    = 1'b1;
        end else begin
          ctrl_code_d = sum_w[CODE_W-1:0];
          up_sat_d    = 1'b0;
          dn_sat_d    = 1'b0;
        end
        // Lock bookkeeping is registered here so it shows up with the code in UPDATE.
        if ((err_q <= TOL_S) && (err_q >= -TOL_S)) begin
          if (lock_cnt_q < LOCK_CNT_L) begin
            lock_cnt_d = lock_cnt_q + LCW'(1);
          end else begin
            lock_cnt_d = lock_cnt_q;
          end
          locked_d = (lock_cnt_d == LOCK_CNT_L);
        end else begin
          lock_cnt_d = '0;
          locked_d   = 1'b0;
        end
        if (fu_s || fd_s) begin
          ovr_d = 1'b1;
        end else begin
          ovr_d = ovr_q;
        end
        state_d = ST_UPDATE;
      end
      ST_UPDATE: begin
        if (fu_s || fd_s) begin
          state_d  = ST_MEAS;
          up_cnt_d = CNT_W'(fu_s);
          dn_cnt_d = CNT_W'(fd_s);
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!RESET) begin
      state_q     <= ST_IDLE;
      up_cnt_q    <= '0;
      dn_cnt_q    <= '0;
      err_q       <= '0;
      integ_q     <= '0;
      ctrl_code_q <= CODE_W'(CODE_INIT);
      lock_cnt_q  <= '0;
      err_valid_q <= 1'b0;
      locked_q    <= 1'b0;
      up_sat_q    <= 1'b0;
      dn_sat_q    <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      up_cnt_q    <= up_cnt_d;
      dn_cnt_q    <= dn_cnt_d;
      err_q       <= err_d;
      integ_q     <= integ_d;
      ctrl_code_q <= ctrl_code_d;
      lock_cnt_q  <= lock_cnt_d;
      err_valid_q <= err_valid_d;
      locked_q    <= locked_d;
      up_sat_q    <= up_sat_d;
      dn_sat_q    <= dn_sat_d;
      ovr_q       <= ovr_d;
    end
  end

  assign ctrl_code = ctrl_code_q;
  assign err       = err_q;
  assign err_valid = err_valid_q;
  assign locked    = locked_q;
  assign up_sat    = up_sat_q;
  assign dn_sat    = dn_sat_q;
  assign ovr       = ovr_q;

endmodule
